lsu_split_access: RTL and testbench

//  Multi-cycle load/store unit: sits between datapath and a req/gnt/rvalid data-memory port.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu_split_access.sv | 150 +++++++++++++++
 tb/tb_lsu_split_access.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the split-access load/store unit: access size, FSM states,
// and width helpers derived from XLEN.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    localparam int BYTE_W = 8;

    function automatic int lsu_bl(input int xlen);
        return xlen / BYTE_W;
    endfunction

    function automatic int lsu_off_w(input int xlen);
        return $clog2(xlen / BYTE_W);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane mask/data placement for both bus beats and load merge with
// sign/zero extension; purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int BL    = XLEN / 8,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [OFF_W-1:0] off,
    input  lsu_size_e        size,
    input  logic             uns,
    input  logic [XLEN-1:0]  st_data,
    input  logic [XLEN-1:0]  ld_beat0,
    input  logic [XLEN-1:0]  ld_beat1,
    output logic [BL-1:0]    mask0,
    output logic [BL-1:0]    mask1,
    output logic [XLEN-1:0]  st_lane0,
    output logic [XLEN-1:0]  st_lane1,
    output logic [XLEN-1:0]  ld_data
);

    localparam logic [2*BL-1:0] ONE2 = 1;

    logic [2*BL-1:0]   m2;
    logic [2*XLEN-1:0] w2;
    logic [2*XLEN-1:0] r2;
    logic [7:0]        byte_v;
    logic              sgn;
    int                n;

    // Double-width shifts: the upper half is exactly what spills into beat 1.
    always_comb begin
        n      = 1 << size;
        m2     = ((ONE2 << n) - ONE2) << off;
        w2     = {{XLEN{1'b0}}, st_data} << (8 * off);
        r2     = {ld_beat1, ld_beat0} >> (8 * off);
        sgn    = 1'b0;
        byte_v = 8'h00;
        for (int b = 0; b < BL; b++) begin
            byte_v = r2[8*b +: 8];
            if (b == n - 1) sgn = byte_v[7] & ~uns;
        end
        for (int b = 0; b < BL; b++) begin
            ld_data[8*b +: 8] = (b < n) ? r2[8*b +: 8] : {8{sgn}};
        end
        mask0    = m2[BL-1:0];
        mask1    = m2[2*BL-1:BL];
        st_lane0 = w2[XLEN-1:0];
        st_lane1 = w2[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/lsu_split_access.sv
// Multi-cycle LSU: registers one request, issues one or two bus beats on a
// req/gnt/rvalid port, merges split loads and returns a single response.
module lsu_split_access
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_uns,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    output logic                   resp_valid,
    output logic [XLEN-1:0]        resp_rdata,
    output logic                   resp_err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [XLEN/8-1:0]      mem_mask,
    output logic [XLEN-1:0]        mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [XLEN-1:0]        mem_rdata
);

    localparam int BL    = lsu_bl(XLEN);
    localparam int OFF_W = lsu_off_w(XLEN);
    localparam int CW    = OFF_W + 4;

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
    lsu_size_e         size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, beat0_q, beat0_d, rdata_q, rdata_d;

    logic [CW-1:0]     n_in;
    logic              mis_in, err_in, cross_q, beat1;
    logic [BL-1:0]     mask0, mask1;
    logic [XLEN-1:0]   st_lane0, st_lane1, ld_beat0, ld_data;
    logic [ADDR_W-1:0] base_addr;

    lsu_align #(.XLEN(XLEN)) u_align (
        .off      (addr_q[OFF_W-1:0]),
        .size     (size_q),
        .uns      (uns_q),
        .st_data  (wdata_q),
        .ld_beat0 (ld_beat0),
        .ld_beat1 (mem_rdata),
        .mask0    (mask0),
        .mask1    (mask1),
        .st_lane0 (st_lane0),
        .st_lane1 (st_lane1),
        .ld_data  (ld_data)
    );

    assign ld_beat0 = (state_q == ST_WAIT1) ? beat0_q : mem_rdata;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat0_d = beat0_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        n_in    = CW'(1) << req_size;
        mis_in  = |(CW'(req_addr[OFF_W-1:0]) & (n_in - CW'(1)));
        err_in  = (req_size == SZ_D && XLEN == 32) || (mis_in && !ALLOW_MISALIGNED);
        cross_q = (CW'(addr_q[OFF_W-1:0]) + (CW'(1) << size_q)) > CW'(BL);
        case (state_q)
            ST_IDLE: if (req_valid) begin
                we_d    = req_we;
                uns_d   = req_uns;
                size_d  = lsu_size_e'(req_size);
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = err_in;
                rdata_d = '0;
                state_d = err_in ? ST_RESP : ST_REQ0;
            end
            ST_REQ0: if (mem_gnt) state_d = ST_WAIT0;
            ST_WAIT0: if (mem_rvalid) begin
                beat0_d = mem_rdata;
                if (cross_q) begin
                    state_d = ST_REQ1;
                end else begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? '0 : ld_data;
                end
            end
            ST_REQ1: if (mem_gnt) state_d = ST_WAIT1;
            ST_WAIT1: if (mem_rvalid) begin
                state_d = ST_RESP;
                rdata_d = we_q ? '0 : ld_data;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus fields come only from registered request state, so they hold until gnt.
    assign base_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign beat1      = (state_q == ST_REQ1);
    assign mem_req    = (state_q == ST_REQ0) || beat1;
    assign mem_we     = mem_req && we_q;
    assign mem_addr   = mem_req ? (base_addr + (beat1 ? ADDR_W'(BL) : '0)) : '0;
    assign mem_mask   = mem_req ? (beat1 ? mask1 : mask0) : '0;
    assign mem_wdata  = mem_req ? (beat1 ? st_lane1 : st_lane0) : '0;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_split_access.sv
// Bench for lsu_split_access: three instances (32-bit, 32-bit strict alignment,
// 64-bit) against a byte-array memory reference model.
module tb_lsu_split_access;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic        req_we = 1'b0, req_uns = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        stall = 1'b0, stray = 1'b0;

    logic        a_ready, a_rv, a_err, a_mreq, a_mwe, a_gnt, a_rvalid_r = 1'b0;
    logic [31:0] a_rd, a_maddr, a_mwdata, a_mrdata = '0;
    logic [3:0]  a_mmask;
    logic        b_ready, b_rv, b_err, b_mreq, b_mwe;
    logic [31:0] b_rd, b_maddr, b_mwdata;
    logic [3:0]  b_mmask;
    logic        c_ready, c_rv, c_err, c_mreq, c_mwe, c_gnt, c_rvalid_r = 1'b0;
    logic [63:0] c_rd, c_mwdata, c_mrdata = '0;
    logic [31:0] c_maddr;
    logic [7:0]  c_mmask;

    int          a_gnts = 0, c_gnts = 0, b_reqs = 0;
    beat_t       a_log[$];
    logic [7:0]  bus_mem[0:511] = '{default: 8'h00};
    logic [7:0]  ref_mem[0:511] = '{default: 8'h00};
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign a_gnt = a_mreq & ~stall;
    assign c_gnt = c_mreq;

    lsu_split_access #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(a_ready), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(a_rv), .resp_rdata(a_rd), .resp_err(a_err), .mem_req(a_mreq), .mem_we(a_mwe),
        .mem_addr(a_maddr), .mem_mask(a_mmask), .mem_wdata(a_mwdata), .mem_gnt(a_gnt),
        .mem_rvalid(a_rvalid_r | stray), .mem_rdata(a_mrdata));

    lsu_split_access #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(b_ready), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(b_rv), .resp_rdata(b_rd), .resp_err(b_err), .mem_req(b_mreq), .mem_we(b_mwe),
        .mem_addr(b_maddr), .mem_mask(b_mmask), .mem_wdata(b_mwdata), .mem_gnt(b_mreq),
        .mem_rvalid(1'b0), .mem_rdata(32'h0));

    lsu_split_access #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(vc), .req_ready(c_ready), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(c_rv), .resp_rdata(c_rd), .resp_err(c_err), .mem_req(c_mreq), .mem_we(c_mwe),
        .mem_addr(c_maddr), .mem_mask(c_mmask), .mem_wdata(c_mwdata), .mem_gnt(c_gnt),
        .mem_rvalid(c_rvalid_r), .mem_rdata(c_mrdata));

    // Zero-wait memory: rvalid the cycle after gnt, byte-addressed backing store.
    always @(posedge clk) begin
        a_rvalid_r <= 1'b0;
        c_rvalid_r <= 1'b0;
        if (a_mreq && a_gnt) begin
            a_gnts     <= a_gnts + 1;
            a_rvalid_r <= 1'b1;
            a_log.push_back({a_maddr, a_mmask, a_mwdata});
            for (int b = 0; b < 4; b++) begin
                a_mrdata[8*b +: 8] <= bus_mem[9'(a_maddr[8:0] + 9'(b))];
                if (a_mwe && a_mmask[b]) bus_mem[9'(a_maddr[8:0] + 9'(b))] <= a_mwdata[8*b +: 8];
            end
        end
        if (c_mreq && c_gnt) begin
            c_gnts     <= c_gnts + 1;
            c_rvalid_r <= 1'b1;
            for (int b = 0; b < 8; b++) begin
                c_mrdata[8*b +: 8] <= bus_mem[9'(c_maddr[8:0] + 9'(b))];
                if (c_mwe && c_mmask[b]) bus_mem[9'(c_maddr[8:0] + 9'(b))] <= c_mwdata[8*b +: 8];
            end
        end
        if (b_mreq) b_reqs <= b_reqs + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_load(input logic [31:0] addr, input int sz,
                                             input logic uns, input int xlen);
        int n = 1 << sz;
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[9'(addr[8:0] + 9'(i))];
        if (!uns && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        if (xlen == 32) v[63:32] = '0;
        return v;
    endfunction

    function automatic logic ref_err(input logic [31:0] addr, input int sz, input int xlen,
                                     input logic allow);
        int n = 1 << sz;
        return (sz == 3 && xlen == 32) || ((addr % n) != 0 && !allow);
    endfunction

    function automatic int ref_beats(input logic [31:0] addr, input int sz, input int xlen,
                                     input logic err);
        int bl = xlen / 8;
        if (err) return 0;
        return ((addr % bl) + (1 << sz) > bl) ? 2 : 1;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input int sz, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[9'(addr[8:0] + 9'(i))] = wd[8*i +: 8];
    endtask

    // Issue one request to instance sel (0=A, 1=B, 2=C) and wait for its response.
    task automatic run_op(input int sel, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output logic err, output int lat,
                          output int beats, output logic timeout);
        int g0 = (sel == 0) ? a_gnts : (sel == 1) ? b_reqs : c_gnts;
        logic rdy, done = 1'b0;
        int cyc = 0;
        @(negedge clk);
        req_we = we; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
        va = (sel == 0); vb = (sel == 1); vc = (sel == 2);
        rdy = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL req_ready sel=%0d: got %b expected 1", sel, rdy);
        end
        @(posedge clk);
        #1 va = 1'b0; vb = 1'b0; vc = 1'b0;
        rd = '0; err = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sel == 0 && a_rv) begin rd = {32'h0, a_rd}; err = a_err; done = 1'b1; end
            if (sel == 1 && b_rv) begin rd = {32'h0, b_rd}; err = b_err; done = 1'b1; end
            if (sel == 2 && c_rv) begin rd = c_rd; err = c_err; done = 1'b1; end
        end
        lat     = cyc;
        beats   = ((sel == 0) ? a_gnts : (sel == 1) ? b_reqs : c_gnts) - g0;
        timeout = !done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_rv, a_err, a_mreq, a_mwe, a_rd, a_maddr, a_mmask, a_mwdata} !== '0 ||
            {c_rv, c_err, c_mreq, c_mwe, c_rd, c_maddr, c_mmask, c_mwdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h/%h/%h c=%h/%h expected all 0",
                     a_rd, a_maddr, a_mmask, c_rd, c_maddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 111", {a_ready, b_ready, c_ready});
        end
    endtask

    task automatic test_directed32;
        logic [63:0] rd; logic err, to; int lat, bt, l0;
        run_op(0, 1, 2, 0, 32'h100, 64'hDEADBEEF, rd, err, lat, bt, to);
        ref_store(32'h100, 2, 64'hDEADBEEF);
        l0 = a_log.size();
        run_op(0, 0, 2, 0, 32'h100, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || rd[31:0] !== 32'hDEADBEEF || lat != 3 || bt != 1 || a_log[l0].mask !== 4'b1111) begin
            errors++;
            $display("FAIL lw_aligned: got %h lat %0d beats %0d mask %b expected deadbeef 3 1 1111",
                     rd[31:0], lat, bt, a_log[l0].mask);
        end
        run_op(0, 1, 2, 0, 32'h100, 64'h80FFFFFF, rd, err, lat, bt, to);
        ref_store(32'h100, 2, 64'h80FFFFFF);
        l0 = a_log.size();
        run_op(0, 0, 0, 0, 32'h103, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || rd[31:0] !== 32'hFFFFFF80 || a_log[l0].mask !== 4'b1000) begin
            errors++;
            $display("FAIL lb_sign: got %h mask %b expected ffffff80 1000", rd[31:0], a_log[l0].mask);
        end
        run_op(0, 0, 0, 1, 32'h103, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || rd[31:0] !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_zero: got %h expected 00000080", rd[31:0]);
        end
        l0 = a_log.size();
        run_op(0, 1, 1, 0, 32'h102, 64'hBEEF, rd, err, lat, bt, to);
        ref_store(32'h102, 1, 64'hBEEF);
        checks++;
        if (to || bt != 1 || a_log[l0] !== {32'h100, 4'b1100, 32'hBEEF0000} || rd !== '0) begin
            errors++;
            $display("FAIL sh_lane: got %h beats %0d rd %h expected 00000100_c_beef0000 1 0",
                     a_log[l0], bt, rd);
        end
        run_op(0, 1, 2, 0, 32'h4, 64'h44332211, rd, err, lat, bt, to);
        ref_store(32'h4, 2, 64'h44332211);
        run_op(0, 1, 2, 0, 32'h8, 64'h88776655, rd, err, lat, bt, to);
        ref_store(32'h8, 2, 64'h88776655);
        run_op(0, 0, 2, 0, 32'h6, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || rd[31:0] !== 32'h66554433 || lat != 5 || bt != 2) begin
            errors++;
            $display("FAIL lw_split: got %h lat %0d beats %0d expected 66554433 5 2", rd[31:0], lat, bt);
        end
        l0 = a_log.size();
        run_op(0, 1, 2, 0, 32'h7, 64'h11223344, rd, err, lat, bt, to);
        ref_store(32'h7, 2, 64'h11223344);
        checks++;
        if (to || bt != 2 || a_log[l0] !== {32'h4, 4'b1000, 32'h44000000} ||
            a_log[l0+1] !== {32'h8, 4'b0111, 32'h00112233}) begin
            errors++;
            $display("FAIL sw_split: got %h %h beats %0d expected 00000004_8_44000000 00000008_7_00112233",
                     a_log[l0], (bt == 2) ? a_log[l0+1] : '0, bt);
        end
    endtask

    task automatic test_errors;
        logic [63:0] rd; logic err, to; int lat, bt;
        run_op(1, 0, 1, 0, 32'h1, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || err !== 1'b1 || lat != 1 || bt != 0 || rd !== '0) begin
            errors++;
            $display("FAIL strict_misaligned: got err %b lat %0d reqs %0d rd %h expected 1 1 0 0",
                     err, lat, bt, rd);
        end
        run_op(0, 0, 3, 0, 32'h100, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || err !== 1'b1 || lat != 1 || bt != 0) begin
            errors++;
            $display("FAIL ld_on_32: got err %b lat %0d beats %0d expected 1 1 0", err, lat, bt);
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h6; va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_rv, a_err, a_mreq, a_mwe, a_rd, a_maddr, a_mmask, a_mwdata} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got rv %b req %b addr %h expected 0 0 0", a_rv, a_mreq, a_maddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_rv !== 1'b0 || a_ready !== 1'b1 || a_mreq !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got rv %b ready %b req %b expected 0 1 0",
                         a_rv, a_ready, a_mreq);
            end
        end
    endtask

    task automatic test_stall;
        logic done = 1'b0; logic ok = 1'b1;
        @(negedge clk);
        stall = 1'b1;
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h47; req_wdata = 64'h11223344; va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a_mreq, a_mwe, a_maddr, a_mmask, a_mwdata} !== {2'b11, 32'h44, 4'b1000, 32'h44000000}) begin
                errors++;
                $display("FAIL stall_hold: got %b %h %b %h expected 1 00000044 1000 44000000",
                         a_mreq, a_maddr, a_mmask, a_mwdata);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (a_rv) done = 1'b1;
        end
        ref_store(32'h47, 2, 64'h11223344);
        for (int i = 0; i < 4; i++) if (bus_mem[9'h47 + 9'(i)] !== ref_mem[9'h47 + 9'(i)]) ok = 1'b0;
        checks++;
        if (!done || !ok) begin
            errors++;
            $display("FAIL stall_store: got done %b bytes_ok %b expected 1 1", done, ok);
        end
    endtask

    task automatic test_xlen64;
        logic [63:0] rd; logic err, to; int lat, bt;
        run_op(2, 1, 3, 0, 32'h0, 64'h80000000_00000000, rd, err, lat, bt, to);
        ref_store(32'h0, 3, 64'h80000000_00000000);
        run_op(2, 0, 2, 1, 32'h4, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || rd !== 64'h00000000_80000000 || lat != 3) begin
            errors++;
            $display("FAIL lwu64: got %h lat %0d expected 0000000080000000 3", rd, lat);
        end
        run_op(2, 0, 2, 0, 32'h4, 64'h0, rd, err, lat, bt, to);
        checks++;
        if (to || rd !== 64'hFFFFFFFF_80000000) begin
            errors++;
            $display("FAIL lw64_sign: got %h expected ffffffff80000000", rd);
        end
    endtask

    task automatic test_random(input int sel, input int xlen, input int count);
        logic [63:0] rd, exp; logic err, to, we, uns, eerr, ok; int lat, bt, sz, eb;
        logic [31:0] addr; logic [63:0] wd;
        for (int k = 0; k < count; k++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = $urandom_range(0, 3);
            addr = $urandom_range(64, 447);
            wd   = {$urandom, $urandom};
            eerr = ref_err(addr, sz, xlen, 1'b1);
            eb   = ref_beats(addr, sz, xlen, eerr);
            exp  = (we || eerr) ? 64'h0 : ref_load(addr, sz, uns, xlen);
            run_op(sel, we, 2'(sz), uns, addr, wd, rd, err, lat, bt, to);
            checks++;
            if (to || err !== eerr || rd !== exp) begin
                errors++;
                $display("FAIL rand%0d_resp we=%b sz=%0d @%h: got err %b rd %h expected %b %h",
                         xlen, we, sz, addr, err, rd, eerr, exp);
            end
            checks++;
            if (bt != eb || lat != (eerr ? 1 : (eb == 2 ? 5 : 3))) begin
                errors++;
                $display("FAIL rand%0d_timing sz=%0d @%h: got beats %0d lat %0d expected %0d %0d",
                         xlen, sz, addr, bt, lat, eb, eerr ? 1 : (eb == 2 ? 5 : 3));
            end
            if (we && !eerr) begin
                ref_store(addr, sz, wd);
                ok = 1'b1;
                for (int i = 0; i < 8; i++)
                    if (bus_mem[9'(addr[8:0] + 9'(i))] !== ref_mem[9'(addr[8:0] + 9'(i))]) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL rand%0d_store sz=%0d @%h: got bus bytes differ expected match",
                             xlen, sz, addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed32();
        test_errors();
        test_xlen64();
        test_stall();
        test_random(0, 32, 40);
        test_random(2, 64, 30);
        test_reset_midop();
        test_random(0, 32, 10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
